// File: rtl/bus_modport_pkg.sv
// Shared definitions for the OCP-style bus monitor.
//   ocp_cmd_e    : request command encoding (MCmd)
//   ocp_resp_e   : response encoding (SResp)
//   ERR_*        : bit positions in err_now / err_sticky
//   cmd_bad()    : true for a disabled or illegal command
package bus_modport_pkg;

  typedef enum logic [2:0] {
    CMD_IDLE = 3'd0,
    CMD_WR   = 3'd1,
    CMD_RD   = 3'd2
  } ocp_cmd_e;

  typedef enum logic [1:0] {
    RESP_NULL = 2'd0,
    RESP_DVA  = 2'd1,
    RESP_FAIL = 2'd2,
    RESP_ERR  = 2'd3
  } ocp_resp_e;

  localparam int ERR_REQ    = 0;
  localparam int ERR_RESP   = 1;
  localparam int ERR_BE     = 2;
  localparam int ERR_CMD    = 3;
  localparam int ERR_ORPHAN = 4;
  localparam int ERR_W      = 5;

  // Encodings above RD have no meaning on this bus and are always flagged.
  function automatic logic cmd_bad(input logic [2:0] cmd,
                                   input logic       rd_en,
                                   input logic       wr_en);
    return ((cmd == CMD_RD) && !rd_en) ||
           ((cmd == CMD_WR) && !wr_en) ||
           (cmd > CMD_RD);
  endfunction

endpackage

// File: rtl/bus_modport_if.sv
// OCP-style bus signal bundle.
//   master  : drives request side and MRespAccept/MReset_n
//   slave   : drives SCmdAccept and response side
//   monitor : observes every signal, drives nothing
interface bus_modport_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) ();

  logic                    MReset_n;
  logic [ADDR_WIDTH-1:0]   MAddr;
  logic [2:0]              MCmd;
  logic [DATA_WIDTH-1:0]   MData;
  logic [DATA_WIDTH/8-1:0] MByteEn;
  logic                    MRespAccept;
  logic                    SCmdAccept;
  logic [DATA_WIDTH-1:0]   SData;
  logic [1:0]              SResp;

  modport master (
    output MReset_n, MAddr, MCmd, MData, MByteEn, MRespAccept,
    input  SCmdAccept, SData, SResp
  );

  modport slave (
    input  MReset_n, MAddr, MCmd, MData, MByteEn, MRespAccept,
    output SCmdAccept, SData, SResp
  );

  modport monitor (
    input MReset_n, MAddr, MCmd, MData, MByteEn, MRespAccept,
    input SCmdAccept, SData, SResp
  );

endinterface

// File: rtl/bus_modport_stable_chk.sv
// Capture-until-accept comparator.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of the pending state (bus reset)
//   trig     : valid but not accepted this edge -> capture cur, go pending
//   acc      : accept; ends the pending phase (that edge is still compared)
//   cur      : value that must stay stable while pending
//   diff     : combinational, pending and cur differs from capture
module bus_modport_stable_chk #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         trig,
  input  logic         acc,
  input  logic [W-1:0] cur,
  output logic         diff
);

  logic         pend;
  logic [W-1:0] cap;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      cap  <= '0;
    end else if (clr) begin
      pend <= 1'b0;
    end else if (pend) begin
      // capture is frozen for the whole pending phase
      if (acc) pend <= 1'b0;
    end else if (trig) begin
      pend <= 1'b1;
      cap  <= cur;
    end
  end

  assign diff = pend && (cur != cap);

endmodule

// File: rtl/bus_modport.sv
// Passive protocol monitor for an OCP-style bus.
//   Clk, Reset : clock, async active-high reset
//   bus        : monitor modport, all bus signals observed only
//   err_now    : registered one-cycle error pulses (bit map in package)
//   err_sticky : OR of all err_now pulses since Reset
//   in_flight  : accepted requests still awaiting a response (saturating)
module bus_modport
  import bus_modport_pkg::*;
#(
  parameter int ADDR_WIDTH       = 32,
  parameter int DATA_WIDTH       = 32,
  parameter int BYTEEN           = 0,
  parameter int CMDACCEPT        = 1,
  parameter int RESPACCEPT       = 1,
  parameter int READ_ENABLE      = 1,
  parameter int WRITE_ENABLE     = 1,
  parameter int WRITERESP_ENABLE = 1,
  parameter int CNT_WIDTH        = 8
) (
  input  logic                 Clk,
  input  logic                 Reset,
  bus_modport_if.monitor       bus,
  output logic [ERR_W-1:0]     err_now,
  output logic [ERR_W-1:0]     err_sticky,
  output logic [CNT_WIDTH-1:0] in_flight
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int REQ_W = 3 + ADDR_WIDTH + DATA_WIDTH + BE_W;
  localparam int RSP_W = 2 + DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic acc_c, acc_r;
  logic req_valid, rsp_valid;
  logic [BE_W-1:0] req_be;
  logic req_diff, rsp_diff;
  logic inc, dec, orphan;
  logic be_err;
  logic [BE_W-1:0] be_prev;
  logic be_seen;
  logic [ERR_W-1:0] err_next;
  logic [ERR_W-1:0] err_q, sticky_q;
  logic [CNT_WIDTH-1:0] cnt_q;

  assign acc_c     = (CMDACCEPT != 0)  ? bus.SCmdAccept  : 1'b1;
  assign acc_r     = (RESPACCEPT != 0) ? bus.MRespAccept : 1'b1;
  assign req_valid = (bus.MCmd != CMD_IDLE);
  assign rsp_valid = (bus.SResp != RESP_NULL);
  // byte enables only take part in request stability when they are in use
  assign req_be    = (BYTEEN != 0) ? bus.MByteEn : '0;

  bus_modport_stable_chk #(.W(REQ_W)) u_req_chk (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (!bus.MReset_n),
    .trig (req_valid && !acc_c),
    .acc  (acc_c),
    .cur  ({bus.MCmd, bus.MAddr, bus.MData, req_be}),
    .diff (req_diff)
  );

  bus_modport_stable_chk #(.W(RSP_W)) u_rsp_chk (
    .clk  (Clk),
    .rst  (Reset),
    .clr  (!bus.MReset_n),
    .trig (rsp_valid && !acc_r),
    .acc  (acc_r),
    .cur  ({bus.SResp, bus.SData}),
    .diff (rsp_diff)
  );

  // Unused byte enables must hold; the first edge after Reset has no
  // previous value to compare against.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      be_prev <= '0;
      be_seen <= 1'b0;
    end else begin
      be_prev <= bus.MByteEn;
      be_seen <= 1'b1;
    end
  end

  assign be_err = (BYTEEN == 0) && be_seen && (bus.MByteEn != be_prev);

  // Illegal command encodings never count as requests expecting a response.
  assign inc = acc_c && ((bus.MCmd == CMD_RD) ||
                         ((bus.MCmd == CMD_WR) && (WRITERESP_ENABLE != 0)));
  assign dec    = rsp_valid && acc_r;
  assign orphan = dec && !inc && (cnt_q == '0);

  always_comb begin
    err_next = '0;
    err_next[ERR_BE] = be_err;
    if (bus.MReset_n) begin
      err_next[ERR_REQ]    = req_diff;
      err_next[ERR_RESP]   = rsp_diff;
      err_next[ERR_CMD]    = cmd_bad(bus.MCmd, READ_ENABLE != 0, WRITE_ENABLE != 0);
      err_next[ERR_ORPHAN] = orphan;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      err_q    <= '0;
      sticky_q <= '0;
    end else begin
      err_q    <= err_next;
      sticky_q <= sticky_q | err_next;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q <= '0;
    end else if (!bus.MReset_n) begin
      cnt_q <= '0;
    end else if (inc && !dec) begin
      if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
    end else if (dec && !inc) begin
      if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
    end
  end

  assign err_now    = err_q;
  assign err_sticky = sticky_q;
  assign in_flight  = cnt_q;

endmodule

// File: tb/tb_bus_modport.sv
module tb_bus_modport;

  logic Clk;
  logic Reset;

  logic [4:0] err_now_a, err_sticky_a, err_now_b, err_sticky_b;
  logic [7:0] in_flight_a;
  logic [1:0] in_flight_b;

  bus_modport_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  // a: default configuration (byte enables unused, all commands enabled)
  bus_modport #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTEEN(0), .CMDACCEPT(1), .RESPACCEPT(1),
    .READ_ENABLE(1), .WRITE_ENABLE(1), .WRITERESP_ENABLE(1), .CNT_WIDTH(8)
  ) dut_a (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .err_now(err_now_a), .err_sticky(err_sticky_a), .in_flight(in_flight_a)
  );

  // b: byte enables used, reads disabled, no write responses, 2-bit counter
  bus_modport #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BYTEEN(1), .CMDACCEPT(1), .RESPACCEPT(1),
    .READ_ENABLE(0), .WRITE_ENABLE(1), .WRITERESP_ENABLE(0), .CNT_WIDTH(2)
  ) dut_b (
    .Clk(Clk), .Reset(Reset), .bus(bus),
    .err_now(err_now_b), .err_sticky(err_sticky_b), .in_flight(in_flight_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [4:0] na;
    logic [4:0] nb;
    int         fa;
    int         fb;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         step = 0;
  logic [4:0] sticky_a = '0;
  logic [4:0] sticky_b = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL step %0d %s observed=%0h expected=%0h", step, tag, obs, exp);
    end
  endtask

  task automatic check_all(input logic [4:0] na, input logic [4:0] nb, input int fa, input int fb);
    chk("err_now_a", 32'(err_now_a), 32'(na));
    chk("err_now_b", 32'(err_now_b), 32'(nb));
    chk("err_sticky_a", 32'(err_sticky_a), 32'(sticky_a));
    chk("err_sticky_b", 32'(err_sticky_b), 32'(sticky_b));
    chk("in_flight_a", 32'(in_flight_a), fa);
    chk("in_flight_b", 32'(in_flight_b), fb);
  endtask

  // Expected outputs are queued with the stimulus and checked after the edge.
  task automatic cyc(input logic [4:0] na, input logic [4:0] nb, input int fa, input int fb);
    exp_t e;
    e.na = na; e.nb = nb; e.fa = fa; e.fb = fb;
    sb.push_back(e);
    step++;
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      sticky_a = sticky_a | e.na;
      sticky_b = sticky_b | e.nb;
      check_all(e.na, e.nb, e.fa, e.fb);
    end
  endtask

  task automatic req(input logic [2:0] c, input logic [31:0] a, input logic ac);
    bus.MCmd = c; bus.MAddr = a; bus.SCmdAccept = ac;
  endtask

  task automatic rsp(input logic [1:0] r, input logic [31:0] d, input logic ac);
    bus.SResp = r; bus.SData = d; bus.MRespAccept = ac;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    bus.MReset_n = 1'b1;
    bus.MData = '0;
    bus.MByteEn = '0;
    req(3'd0, 32'h0, 1'b1);
    rsp(2'd0, 32'h0, 1'b1);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;
    check_all(5'b0, 5'b0, 0, 0);

    // request stability: address moves while not accepted
    req(3'd2, 32'h10, 1'b0); cyc(5'b00000, 5'b01000, 0, 0);
    req(3'd2, 32'h14, 1'b0); cyc(5'b00001, 5'b01001, 0, 0);
    req(3'd2, 32'h10, 1'b1); cyc(5'b00000, 5'b01000, 1, 1);
    req(3'd0, 32'h0,  1'b1); cyc(5'b00000, 5'b00000, 1, 1);

    // response held stable for three cycles, then accepted
    rsp(2'd1, 32'hAA, 1'b0); cyc(5'b0, 5'b0, 1, 1);
    cyc(5'b0, 5'b0, 1, 1);
    cyc(5'b0, 5'b0, 1, 1);
    rsp(2'd1, 32'hAA, 1'b1); cyc(5'b0, 5'b0, 0, 0);

    // response data changes before accept
    rsp(2'd0, 32'h0, 1'b1); req(3'd2, 32'h20, 1'b1); cyc(5'b00000, 5'b01000, 1, 1);
    req(3'd0, 32'h0, 1'b1); rsp(2'd1, 32'hAA, 1'b0); cyc(5'b0, 5'b0, 1, 1);
    rsp(2'd1, 32'hBB, 1'b0); cyc(5'b00010, 5'b00010, 1, 1);
    rsp(2'd1, 32'hAA, 1'b1); cyc(5'b0, 5'b0, 0, 0);
    rsp(2'd0, 32'h0, 1'b1);  cyc(5'b0, 5'b0, 0, 0);

    // byte enables: flagged only where they are unused
    bus.MByteEn = 4'hF; cyc(5'b00100, 5'b0, 0, 0);
    bus.MByteEn = 4'h3; cyc(5'b00100, 5'b0, 0, 0);
    cyc(5'b0, 5'b0, 0, 0);
    bus.MByteEn = 4'h0; cyc(5'b00100, 5'b0, 0, 0);

    // in-flight counting and orphan responses
    req(3'd2, 32'h30, 1'b1); cyc(5'b0, 5'b01000, 1, 1);
    req(3'd2, 32'h34, 1'b1); cyc(5'b0, 5'b01000, 2, 2);
    req(3'd1, 32'h38, 1'b1); cyc(5'b0, 5'b0, 3, 2);
    req(3'd0, 32'h0, 1'b1); rsp(2'd1, 32'h0, 1'b1); cyc(5'b0, 5'b0, 2, 1);
    cyc(5'b0, 5'b0, 1, 0);
    cyc(5'b0, 5'b10000, 0, 0);
    cyc(5'b10000, 5'b10000, 0, 0);
    rsp(2'd0, 32'h0, 1'b1); cyc(5'b0, 5'b0, 0, 0);

    // simultaneous inc/dec, then saturation of the 2-bit counter
    req(3'd2, 32'h40, 1'b1); cyc(5'b0, 5'b01000, 1, 1);
    req(3'd2, 32'h44, 1'b1); rsp(2'd1, 32'h0, 1'b1); cyc(5'b0, 5'b01000, 1, 1);
    rsp(2'd0, 32'h0, 1'b1); cyc(5'b0, 5'b01000, 2, 2);
    cyc(5'b0, 5'b01000, 3, 3);
    cyc(5'b0, 5'b01000, 4, 3);
    cyc(5'b0, 5'b01000, 5, 3);
    req(3'd0, 32'h0, 1'b1); cyc(5'b0, 5'b0, 5, 3);

    // illegal command left pending, then bus reset
    req(3'd5, 32'h0, 1'b0); cyc(5'b01000, 5'b01000, 5, 3);
    bus.MReset_n = 1'b0; bus.MByteEn = 4'hF; req(3'd2, 32'h50, 1'b1);
    cyc(5'b00100, 5'b0, 0, 0);
    bus.MReset_n = 1'b1; req(3'd0, 32'h0, 1'b1); cyc(5'b0, 5'b0, 0, 0);
    bus.MByteEn = 4'h0; cyc(5'b00100, 5'b0, 0, 0);

    // async reset mid-stream with requests outstanding
    req(3'd2, 32'h60, 1'b1); cyc(5'b0, 5'b01000, 1, 1);
    cyc(5'b0, 5'b01000, 2, 2);
    cyc(5'b0, 5'b01000, 3, 3);
    req(3'd0, 32'h0, 1'b1);
    #2 Reset = 1'b1;
    #1;
    sticky_a = '0;
    sticky_b = '0;
    step++;
    check_all(5'b0, 5'b0, 0, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    cyc(5'b0, 5'b0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_modport.md
Name: bus_modport

Overview:
- Passive protocol monitor for the OCP-style Bus interface signal set.
- Taps the master and slave modport signals in parallel; never drives the bus.
- Checks request stability, response stability, byte-enable misuse, disabled commands and orphan responses in synthesizable RTL.
- Reports per-cycle error pulses, sticky error flags and an outstanding-transaction count, for simulation and on-chip debug.

Parameters:
- ADDR_WIDTH, 32, MAddr width.
- DATA_WIDTH, 32, MData/SData width; must be a multiple of 8. MByteEn width is DATA_WIDTH/8.
- BYTEEN, 0, 1 = MByteEn in use; 0 = MByteEn must never change.
- CMDACCEPT, 1, 0 = SCmdAccept treated as constant 1.
- RESPACCEPT, 1, 0 = MRespAccept treated as constant 1.
- READ_ENABLE, 1, RD command permitted.
- WRITE_ENABLE, 1, WR command permitted.
- WRITERESP_ENABLE, 1, accepted WR expects a response.
- CNT_WIDTH, 8, in-flight counter width.

Ports:
- Clk  input  1  clock; all logic on posedge.
- Reset  input  1  asynchronous, active-high; clears all state.
- MReset_n  input  1  bus reset (active-low); while low, checks disabled and tracking cleared synchronously.
- MAddr  input  ADDR_WIDTH  request address.
- MCmd  input  3  Ocp_cmd: IDLE=0, WR=1, RD=2; other values are illegal.
- MData  input  DATA_WIDTH  write data.
- MByteEn  input  DATA_WIDTH/8  byte enables.
- MRespAccept  input  1  master accepts response.
- SCmdAccept  input  1  slave accepts request.
- SData  input  DATA_WIDTH  read data.
- SResp  input  2  Ocp_resp: NULL=0, DVA=1, FAIL=2, ERR=3.
- err_now  output  5  one-cycle error pulses.
- err_sticky  output  5  sticky error flags.
- in_flight  output  CNT_WIDTH  accepted requests awaiting a response.

Behaviour:
- Error bit map (err_now and err_sticky):
  - 0 request unstable
  - 1 response unstable
  - 2 MByteEn changed with BYTEEN=0
  - 3 disabled or illegal command
  - 4 response with nothing in flight
- Reset (async): all outputs 0, all capture registers and pending flags 0.
- Sampling and latency: inputs sampled at posedge. err_now is registered and is high during the cycle following the edge where the violation was sampled. err_sticky bit sets in the same cycle as err_now and holds until Reset.
- Effective accepts: acc_c = CMDACCEPT ? SCmdAccept : 1; acc_r = RESPACCEPT ? MRespAccept : 1.
- Request tracking:
  - Edge with MCmd!=IDLE && !acc_c: set req_pend; capture MCmd, MAddr, MData, and MByteEn if BYTEEN=1.
  - While req_pend, any later edge where MCmd, MAddr, MData (or MByteEn if BYTEEN) differs from the capture: pulse bit 0.
  - req_pend clears at the edge with acc_c=1; that edge is still compared.
  - One error per mismatching edge. Capture is not updated while pending.
- Response tracking:
  - Same scheme with trigger SResp!=NULL && !acc_r.
  - Captures SResp and SData; compares them; pulses bit 1.
- Byte-enable check (BYTEEN=0): MByteEn differs from its value at the previous edge -> bit 2. Active regardless of MReset_n; gated only by Reset.
- Command check: edge with MCmd==RD && !READ_ENABLE, MCmd==WR && !WRITE_ENABLE, or MCmd>2 -> bit 3. Flagged once per edge, not only on accept.
- In-flight counting:
  - inc = accepted request (MCmd!=IDLE && acc_c) that is RD, or WR with WRITERESP_ENABLE.
  - dec = SResp!=NULL && acc_r.
  - Simultaneous inc and dec: count unchanged.
  - dec with count==0 and no inc: pulse bit 4; count stays 0.
  - inc at all-ones: count saturates and holds.
- MReset_n low at an edge: req_pend, resp_pend and in_flight clear; bits 0, 1, 3 and 4 are not raised; err_sticky is kept.

Decomposition:
- Shared package Bus holds Ocp_cmd (IDLE, WR, RD) and Ocp_resp (NULL, DVA, FAIL, ERR) enums, plus error-bit index constants.
- One natural sub-module, bus_modport_stable_chk: a generic capture-until-accept comparator, parameterized by width.
  - Instantiated twice: request (cmd+addr+data[+byteen]) and response (resp+data).

Test Plan:
- Reset asserted mid-stream with err_sticky=5'b00011 and in_flight=3 -> all outputs 0 immediately, before the next edge.
- RD at addr 0x10 with SCmdAccept low for 2 cycles, addr changed to 0x14 in cycle 2 -> err_now[0] pulses once, err_sticky[0]=1.
- SResp=DVA, SData=0xAA held 3 cycles with MRespAccept low, then accepted -> no error. Repeat with SData changed to 0xBB before accept -> err_now[1]=1.
- BYTEEN=0, MByteEn toggles 0xF->0x3 -> err_now[2]=1. BYTEEN=1, same toggle -> no error.
- Two accepted RDs, then accepted WR with WRITERESP_ENABLE=0 -> in_flight=2. Two DVA responses accepted -> 0. A third response -> err_now[4]=1, in_flight stays 0.
- READ_ENABLE=0 and MCmd=RD for one cycle -> err_now[3]=1. MCmd=5 -> err_now[3]=1. MReset_n=0 with MCmd=RD -> no error.
